hex_display_scanner: RTL and testbench

- Parametrised, time-multiplexed driver for NUM_DIGITS common-segment 7-segment digits. Each digit shows one hex nibble (0-F).
- Captures a packed value into a shadow register and scans one digit per scan tick.
- Adds per-digit blanking, leading-zero suppression, whole-display blink and selectable segment polarity.
- Sits between the datapath result registers and the board's multiplexed display pins.

---
 rtl/hex_display_scanner_if.sv | 25 ++
 rtl/hex_display_scanner.sv | 113 +++++++++++
 tb/tb_hex_display_scanner.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scanner_if.sv
// Bus between the datapath and the multiplexed 7-segment display scanner.
// The master side supplies the value and display controls. The slave side
// drives the segment pins, the digit enables and the end-of-frame pulse.
interface hex_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_suppress;
  logic                    blink_en;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;

  modport master (
    output load, value, blank_mask, lz_suppress, blink_en,
    input  seg, dig_en, frame_done
  );

  modport slave (
    input  load, value, blank_mask, lz_suppress, blink_en,
    output seg, dig_en, frame_done
  );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex driver for NUM_DIGITS 7-segment digits.
// A shadow register holds the value, so a frame never shows mixed data.
// One digit is scanned per prescaler tick. Per-digit blanking, leading-zero
// suppression and whole-display blink are applied before the registered
// output stage. The output stage also applies the pin polarity.
module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 256,
  parameter int ACTIVE_LOW = 1
) (
  input logic                  clk,
  input logic                  reset,
  hex_display_scanner_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                  tick;
  logic                  dark;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic [3:0]            nib;

  // Segment glyph for a nibble. Bit k drives segment k, active-high.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Next state for the scan counters, blink phase, shadow and output stage.
  always_comb begin
    tick         = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    frame_done_d = tick && (idx_q == IW'(NUM_DIGITS - 1));
    if (tick) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    shadow_d = bus.load ? bus.value : shadow_q;

    // Walk from the top digit down. A digit counts as a leading zero while
    // every nibble from it up to the top digit is zero. Digit 0 is exempt,
    // so a zero value still shows a single "0".
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (shadow_q[4*k +: 4] == 4'h0);
      lz_dark[k] = zero_run && (k != 0);
    end

    nib  = shadow_q[idx_q*4 +: 4];
    dark = bus.blank_mask[idx_q] || (bus.blink_en && phase_q) ||
           (bus.lz_suppress && lz_dark[idx_q]);
    seg_d    = (dark ? 7'h00 : glyph(nib)) ^ SEG_OFF;
    dig_en_d = (dark ? '0 : (NUM_DIGITS'(1) << idx_q)) ^ DIG_OFF;
  end

  // State registers. Reset drives the pins to their inactive level at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      shadow_q     <= '0;
      seg_q        <= SEG_OFF;
      dig_en_q     <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_en     = dig_en_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner with NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2
// and active-low pins. Tasks queue the pin state expected for every cycle of
// a frame. The monitor starts draining the queue on the cycle after a
// frame_done pulse, which is the first cycle of digit 0.
module tb_hex_display_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hex_display_scanner_if #(.NUM_DIGITS(4)) bus();

  hex_display_scanner #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_arm  = 1'b0;
  bit   sb_run  = 1'b0;
  int   sb_idx  = 0;

  // Scoreboard monitor: checks one queued entry per cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_run) begin
      if (sb_q.size() == 0) begin
        sb_run = 1'b0;
      end else begin
        e = sb_q.pop_front();
        n_tests++;
        if (bus.dig_en !== e.dig || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
          n_fail++;
          $display("FAIL sb[%0d] got dig_en=%h seg=%h frame_done=%b, expected dig_en=%h seg=%h frame_done=%b",
                   sb_idx, bus.dig_en, bus.seg, bus.frame_done, e.dig, e.seg, e.fd);
        end
        sb_idx++;
        if (sb_q.size() == 0) sb_run = 1'b0;
      end
    end else if (sb_arm && bus.frame_done === 1'b1) begin
      sb_arm = 1'b0;
      sb_run = 1'b1;
      sb_idx = 0;
    end
  end

  // Queue one 4-cycle digit slot. The last slot of a frame carries frame_done
  // on its final cycle.
  function automatic void push_slot(input logic [3:0] dig, input logic [6:0] seg, input bit last);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.dig = dig;
      e.seg = seg;
      e.fd  = last && (i == 3);
      sb_q.push_back(e);
    end
  endfunction

  task automatic run_sb(input string name);
    sb_arm = 1'b1;
    for (int i = 0; i < 200 && (sb_arm || sb_run); i++) @(negedge clk);
    n_tests++;
    if (sb_arm || sb_run || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s scoreboard timeout: %0d entries left, required 0", name, sb_q.size());
      sb_arm = 1'b0;
      sb_run = 1'b0;
      sb_q.delete();
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.value = '0; bus.blank_mask = '0;
    bus.lz_suppress = 1'b0; bus.blink_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.seg !== 7'h7F || bus.dig_en !== 4'hF || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got seg=%h dig_en=%h fd=%b, expected seg=7f dig_en=f fd=0",
               bus.seg, bus.dig_en, bus.frame_done);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.dig_en !== 4'hE || bus.seg !== 7'h40) begin
        n_fail++;
        $display("FAIL reset_d0_hold[%0d] got dig_en=%h seg=%h, expected dig_en=e seg=40", i, bus.dig_en, bus.seg);
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.dig_en !== 4'hD || bus.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL reset_d1_start got dig_en=%h seg=%h, expected dig_en=d seg=40", bus.dig_en, bus.seg);
    end
    push_slot(4'hE, 7'h40, 0); push_slot(4'hD, 7'h40, 0);
    push_slot(4'hB, 7'h40, 0); push_slot(4'h7, 7'h40, 1);
    run_sb("reset_zero_frame");
  endtask

  task automatic test_value();
    do_load(16'h12AF);
    for (int f = 0; f < 2; f++) begin
      push_slot(4'hE, 7'h0E, 0); push_slot(4'hD, 7'h08, 0);
      push_slot(4'hB, 7'h24, 0); push_slot(4'h7, 7'h79, 1);
    end
    run_sb("value_12af");
  endtask

  task automatic test_lz();
    bus.lz_suppress = 1'b1;
    do_load(16'h0050);
    push_slot(4'hE, 7'h40, 0); push_slot(4'hD, 7'h12, 0);
    push_slot(4'hF, 7'h7F, 0); push_slot(4'hF, 7'h7F, 1);
    run_sb("lz_0050");
    do_load(16'h0000);
    push_slot(4'hE, 7'h40, 0); push_slot(4'hF, 7'h7F, 0);
    push_slot(4'hF, 7'h7F, 0); push_slot(4'hF, 7'h7F, 1);
    run_sb("lz_0000");
    bus.lz_suppress = 1'b0;
  endtask

  task automatic test_blank();
    bus.blank_mask = 4'b0101;
    do_load(16'h8888);
    push_slot(4'hF, 7'h7F, 0); push_slot(4'hD, 7'h00, 0);
    push_slot(4'hF, 7'h7F, 0); push_slot(4'h7, 7'h00, 1);
    run_sb("blank_0101");
    bus.blank_mask = 4'b0000;
  endtask

  task automatic test_blink();
    // Two ticks per half-period and four ticks per frame, so every frame
    // has digits 0-1 lit (phase 0) and digits 2-3 dark (phase 1).
    bus.blink_en = 1'b1;
    do_load(16'h8888);
    for (int f = 0; f < 2; f++) begin
      push_slot(4'hE, 7'h00, 0); push_slot(4'hD, 7'h00, 0);
      push_slot(4'hF, 7'h7F, 0); push_slot(4'hF, 7'h7F, 1);
    end
    run_sb("blink");
    bus.blink_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    do_load(16'h1234);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_frame_sync no frame_done within 40 cycles, required one");
    end
    repeat (9) @(negedge clk);
    n_tests++;
    if (bus.dig_en !== 4'hB || bus.seg !== 7'h24) begin
      n_fail++;
      $display("FAIL mid_d2 got dig_en=%h seg=%h, expected dig_en=b seg=24", bus.dig_en, bus.seg);
    end
    // A load in the middle of the slot changes seg one cycle after capture.
    bus.value = 16'h0F00;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    n_tests++;
    if (bus.seg !== 7'h24) begin
      n_fail++;
      $display("FAIL midslot_old got seg=%h, expected seg=24", bus.seg);
    end
    @(negedge clk);
    n_tests++;
    if (bus.dig_en !== 4'hB || bus.seg !== 7'h0E) begin
      n_fail++;
      $display("FAIL midslot_new got dig_en=%h seg=%h, expected dig_en=b seg=0e", bus.dig_en, bus.seg);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.seg !== 7'h7F || bus.dig_en !== 4'hF || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got seg=%h dig_en=%h fd=%b, expected seg=7f dig_en=f fd=0",
               bus.seg, bus.dig_en, bus.frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.dig_en !== 4'hE || bus.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL restart_d0 got dig_en=%h seg=%h, expected dig_en=e seg=40", bus.dig_en, bus.seg);
    end
    push_slot(4'hE, 7'h40, 0); push_slot(4'hD, 7'h40, 0);
    push_slot(4'hB, 7'h40, 0); push_slot(4'h7, 7'h40, 1);
    run_sb("restart_zero_frame");
  endtask

  initial begin
    test_reset();
    test_value();
    test_lz();
    test_blank();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
